// File: rtl/soc_reset_sequencer_if.sv
// Reset sequencer bus: groups the lock/software-request inputs with the
// staged reset outputs and reset-cause readback.
//   pll_lock    PLL lock from the clock generator (asynchronous to main_clk)
//   sw_rst_req  single-cycle software reset request (synchronous)
//   periph_rst  active-high peripheral reset
//   core_rst    active-high core reset
//   rst_done    both resets released
//   rst_cause   00 external/power-on, 01 PLL lock loss, 10 software
interface soc_reset_sequencer_if;

    logic       pll_lock;
    logic       sw_rst_req;
    logic       periph_rst;
    logic       core_rst;
    logic       rst_done;
    logic [1:0] rst_cause;

    // Sequencer side: consumes lock/request, drives resets and cause.
    modport master (
        input  pll_lock,
        input  sw_rst_req,
        output periph_rst,
        output core_rst,
        output rst_done,
        output rst_cause
    );

    // Consumer side: clock generator / software / reset sinks.
    modport slave (
        output pll_lock,
        output sw_rst_req,
        input  periph_rst,
        input  core_rst,
        input  rst_done,
        input  rst_cause
    );

endinterface

// File: rtl/soc_reset_sequencer.sv
// Staged reset sequencer for the SoC main clock domain. Waits for a
// synchronized PLL lock, releases peripheral reset after PERIPH_DELAY
// cycles and core reset CORE_DELAY cycles later. Lock loss or a software
// request re-asserts both resets together; the cause of the latest reset
// is held for software readback.
//   main_clk  sole clock, all state on its rising edge
//   in_rst_n  asynchronous active-low reset (synchronous deassertion)
//   rst_bus   master modport: pll_lock, sw_rst_req in;
//             periph_rst, core_rst, rst_done, rst_cause out (all registered)
module soc_reset_sequencer #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned PERIPH_DELAY  = 8,
    parameter int unsigned CORE_DELAY    = 16,
    parameter int unsigned SW_RST_CYCLES = 32
) (
    input  logic                   main_clk,
    input  logic                   in_rst_n,
    soc_reset_sequencer_if.master  rst_bus
);

    localparam int unsigned MAX_PC    = (PERIPH_DELAY > CORE_DELAY) ? PERIPH_DELAY : CORE_DELAY;
    localparam int unsigned MAX_DELAY = (MAX_PC > SW_RST_CYCLES) ? MAX_PC : SW_RST_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_DELAY) + 1;

    localparam logic [CNT_W-1:0] PERIPH_LOAD = CNT_W'(PERIPH_DELAY - 1);
    localparam logic [CNT_W-1:0] CORE_LOAD   = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] SW_LOAD     = CNT_W'(SW_RST_CYCLES - 1);

    localparam logic [1:0] CAUSE_EXT = 2'b00;
    localparam logic [1:0] CAUSE_PLL = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [2:0] {
        WAIT_LOCK   = 3'd0,
        PERIPH_WAIT = 3'd1,
        CORE_WAIT   = 3'd2,
        RUN         = 3'd3,
        SW_HOLD     = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             periph_q, periph_d;
    logic             core_q,   core_d;
    logic             done_q,   done_d;
    logic [1:0]       cause_q,  cause_d;

    // PLL lock synchronizer; only the last stage feeds the FSM.
    always_ff @(posedge main_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rst_bus.pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // State, counter and registered outputs.
    always_ff @(posedge main_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q  <= WAIT_LOCK;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            core_q   <= 1'b1;
            done_q   <= 1'b0;
            cause_q  <= CAUSE_EXT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            done_q   <= done_d;
            cause_q  <= cause_d;
        end
    end

    // Next-state and next-output logic; lock loss overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        done_d   = done_q;
        cause_d  = cause_q;

        if ((state_q != WAIT_LOCK) && !lock_s) begin
            periph_d = 1'b1;
            core_d   = 1'b1;
            done_d   = 1'b0;
            cause_d  = CAUSE_PLL;
            state_d  = WAIT_LOCK;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    done_d   = 1'b0;
                    if (lock_s) begin
                        cnt_d   = PERIPH_LOAD;
                        state_d = PERIPH_WAIT;
                    end
                end
                PERIPH_WAIT: begin
                    if (cnt_q == '0) begin
                        periph_d = 1'b0;
                        cnt_d    = CORE_LOAD;
                        state_d  = CORE_WAIT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                CORE_WAIT: begin
                    if (cnt_q == '0) begin
                        core_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                RUN: begin
                    // Requests outside RUN are dropped, not queued.
                    if (rst_bus.sw_rst_req) begin
                        periph_d = 1'b1;
                        core_d   = 1'b1;
                        done_d   = 1'b0;
                        cnt_d    = SW_LOAD;
                        cause_d  = CAUSE_SW;
                        state_d  = SW_HOLD;
                    end
                end
                SW_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    periph_d = 1'b1;
                    core_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_bus.periph_rst = periph_q;
    assign rst_bus.core_rst   = core_q;
    assign rst_bus.rst_done   = done_q;
    assign rst_bus.rst_cause  = cause_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer: stimulus pushes the expected
// output transitions (edge number + output tuple); a monitor pops and
// compares each time the outputs change.
module tb_soc_reset_sequencer;

    logic main_clk;
    logic in_rst_n;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        int         at_edge;
        logic       p;
        logic       c;
        logic       d;
        logic [1:0] cause;
    } exp_t;

    exp_t exp_q[$];

    soc_reset_sequencer_if rst_bus ();

    soc_reset_sequencer #(
        .SYNC_STAGES   (2),
        .PERIPH_DELAY  (8),
        .CORE_DELAY    (16),
        .SW_RST_CYCLES (32)
    ) dut (
        .main_clk (main_clk),
        .in_rst_n (in_rst_n),
        .rst_bus  (rst_bus)
    );

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    initial cyc = 0;
    always @(posedge main_clk) cyc <= cyc + 1;

    task automatic push(input int e, input logic p, input logic c, input logic d,
                        input logic [1:0] cause);
        exp_t x;
        x.at_edge = e;
        x.p = p;
        x.c = c;
        x.d = d;
        x.cause = cause;
        exp_q.push_back(x);
    endtask

    task automatic goto_neg(input int e);
        @(negedge main_clk);
        while (cyc < e) @(negedge main_clk);
    endtask

    task automatic check_reset_now(input string name);
        n_cmp++;
        if (rst_bus.periph_rst !== 1'b1 || rst_bus.core_rst !== 1'b1 ||
            rst_bus.rst_done !== 1'b0 || rst_bus.rst_cause !== 2'b00) begin
            n_bad++;
            $display("FAIL %s: got p=%b c=%b d=%b cause=%b, want p=1 c=1 d=0 cause=00",
                     name, rst_bus.periph_rst, rst_bus.core_rst, rst_bus.rst_done,
                     rst_bus.rst_cause);
        end
    endtask

    // Monitor: compare each output change against the next expected event.
    logic       prev_p, prev_c, prev_d;
    logic [1:0] prev_cause;
    initial begin
        exp_t x;
        prev_p = 1'b1; prev_c = 1'b1; prev_d = 1'b0; prev_cause = 2'b00;
        forever begin
            @(negedge main_clk);
            if (in_rst_n) begin
                n_cmp++;
                if (rst_bus.core_rst === 1'b0 && rst_bus.periph_rst !== 1'b0) begin
                    n_bad++;
                    $display("FAIL invariant @edge %0d: core_rst=0 with periph_rst=%b",
                             cyc, rst_bus.periph_rst);
                end
            end
            if (rst_bus.periph_rst !== prev_p || rst_bus.core_rst !== prev_c ||
                rst_bus.rst_done !== prev_d || rst_bus.rst_cause !== prev_cause) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change @edge %0d: p=%b c=%b d=%b cause=%b",
                             cyc, rst_bus.periph_rst, rst_bus.core_rst, rst_bus.rst_done,
                             rst_bus.rst_cause);
                end else begin
                    x = exp_q.pop_front();
                    if (cyc != x.at_edge || rst_bus.periph_rst !== x.p ||
                        rst_bus.core_rst !== x.c || rst_bus.rst_done !== x.d ||
                        rst_bus.rst_cause !== x.cause) begin
                        n_bad++;
                        $display("FAIL transition: got edge %0d p=%b c=%b d=%b cause=%b, want edge %0d p=%b c=%b d=%b cause=%b",
                                 cyc, rst_bus.periph_rst, rst_bus.core_rst, rst_bus.rst_done,
                                 rst_bus.rst_cause, x.at_edge, x.p, x.c, x.d, x.cause);
                    end
                end
                prev_p     = rst_bus.periph_rst;
                prev_c     = rst_bus.core_rst;
                prev_d     = rst_bus.rst_done;
                prev_cause = rst_bus.rst_cause;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        int d;
        int n;
        n_cmp = 0;
        n_bad = 0;
        in_rst_n = 1'b1;
        rst_bus.pll_lock   = 1'b1;
        rst_bus.sw_rst_req = 1'b0;
        #1 in_rst_n = 1'b0;
        #1 check_reset_now("por_reset_values");

        // Power-up with lock already high.
        goto_neg(2);
        in_rst_n = 1'b1;
        b = cyc;
        push(b + 11, 1'b0, 1'b1, 1'b0, 2'b00);
        push(b + 27, 1'b0, 1'b0, 1'b1, 2'b00);

        // Re-reset, then lock loss during PERIPH_WAIT (edge 6), return at edge 20.
        goto_neg(b + 32);
        @(posedge main_clk);
        #2 in_rst_n = 1'b0;
        #1 check_reset_now("async_reset_from_run");
        push(cyc, 1'b1, 1'b1, 1'b0, 2'b00);
        goto_neg(cyc + 1);
        in_rst_n = 1'b1;
        b = cyc;
        goto_neg(b + 5);
        rst_bus.pll_lock = 1'b0;
        push(b + 8, 1'b1, 1'b1, 1'b0, 2'b01);
        goto_neg(b + 19);
        rst_bus.pll_lock = 1'b1;
        push(b + 30, 1'b0, 1'b1, 1'b0, 2'b01);
        push(b + 46, 1'b0, 1'b0, 1'b1, 2'b01);

        // One-cycle lock glitch in RUN.
        goto_neg(b + 50);
        d = cyc;
        rst_bus.pll_lock = 1'b0;
        push(d + 3, 1'b1, 1'b1, 1'b0, 2'b01);
        goto_neg(d + 1);
        rst_bus.pll_lock = 1'b1;
        push(d + 12, 1'b0, 1'b1, 1'b0, 2'b01);
        push(d + 28, 1'b0, 1'b0, 1'b1, 2'b01);

        // Software reset in RUN, lock held.
        goto_neg(d + 32);
        n = cyc + 1;
        rst_bus.sw_rst_req = 1'b1;
        push(n, 1'b1, 1'b1, 1'b0, 2'b10);
        goto_neg(n);
        rst_bus.sw_rst_req = 1'b0;
        push(n + 41, 1'b0, 1'b1, 1'b0, 2'b10);
        push(n + 57, 1'b0, 1'b0, 1'b1, 2'b10);

        // Software request on the same edge lock_s falls; later request in CORE_WAIT ignored.
        goto_neg(n + 60);
        d = cyc;
        rst_bus.pll_lock = 1'b0;
        push(d + 3, 1'b1, 1'b1, 1'b0, 2'b01);
        goto_neg(d + 2);
        rst_bus.sw_rst_req = 1'b1;
        goto_neg(d + 3);
        rst_bus.sw_rst_req = 1'b0;
        goto_neg(d + 5);
        rst_bus.pll_lock = 1'b1;
        push(d + 16, 1'b0, 1'b1, 1'b0, 2'b01);
        push(d + 32, 1'b0, 1'b0, 1'b1, 2'b01);
        goto_neg(d + 19);
        rst_bus.sw_rst_req = 1'b1;
        goto_neg(d + 20);
        rst_bus.sw_rst_req = 1'b0;

        // Async reset in the middle of SW_HOLD, then nominal power-up.
        goto_neg(d + 35);
        n = cyc + 1;
        rst_bus.sw_rst_req = 1'b1;
        push(n, 1'b1, 1'b1, 1'b0, 2'b10);
        goto_neg(n);
        rst_bus.sw_rst_req = 1'b0;
        goto_neg(n + 9);
        @(posedge main_clk);
        #2 in_rst_n = 1'b0;
        #1 check_reset_now("async_reset_in_sw_hold");
        push(cyc, 1'b1, 1'b1, 1'b0, 2'b00);
        goto_neg(n + 12);
        in_rst_n = 1'b1;
        b = cyc;
        push(b + 11, 1'b0, 1'b1, 1'b0, 2'b00);
        push(b + 27, 1'b0, 1'b0, 1'b1, 2'b00);
        goto_neg(b + 32);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: got %0d unobserved transitions, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/soc_reset_sequencer.md
# soc_reset_sequencer

Staged reset sequencer on the SoC main clock: consumes the external/system reset, the clock generator's PLL lock indication and a software reset request, and releases peripheral reset before core reset after programmable delays. It sits directly downstream of the SoC clock and reset generator and is the single source of `periph_rst` and `core_rst` for the main clock domain. It also records the cause of the most recent reset for software readback.

## Interface
- `SYNC_STAGES`, 2: flops in the `pll_lock` synchronizer (>= 2).
- `PERIPH_DELAY`, 8: cycles from synchronized lock to `periph_rst` release (>= 1).
- `CORE_DELAY`, 16: cycles from `periph_rst` release to `core_rst` release (>= 1).
- `SW_RST_CYCLES`, 32: cycles both resets are held for a software reset (>= 1).

- `main_clk`  in  1  sole clock, all state on its rising edge.
- `in_rst_n`  in  1  asynchronous active-low reset; deassertion arrives already synchronous to `main_clk`.
- `pll_lock`  in  1  PLL lock, asynchronous to `main_clk`.
- `sw_rst_req`  in  1  software reset request, single-cycle pulse, synchronous.
- `periph_rst`  out  1  active-high peripheral reset, registered.
- `core_rst`  out  1  active-high core reset, registered.
- `rst_done`  out  1  high when both resets are released (state RUN).
- `rst_cause`  out  2  00 external/power-on, 01 PLL lock loss, 10 software, 11 unused.

## Operation
- `in_rst_n` low, applied asynchronously:
  - `periph_rst` = 1, `core_rst` = 1, `rst_done` = 0, `rst_cause` = 00.
  - Synchronizer flops = 0, counter = 0, state = WAIT_LOCK.
- Lock synchronizer: `SYNC_STAGES` flops in series. The last flop is `lock_s`, the only lock signal the FSM uses.
- Counter width is `$clog2` of max(`PERIPH_DELAY`, `CORE_DELAY`, `SW_RST_CYCLES`) + 1. The counter only loads and decrements; it never wraps.
- FSM states:
  - WAIT_LOCK: both resets asserted. On `lock_s`=1: counter <= `PERIPH_DELAY`-1, go to PERIPH_WAIT.
  - PERIPH_WAIT: decrement each cycle. When counter==0: `periph_rst` <= 0, counter <= `CORE_DELAY`-1, go to CORE_WAIT.
  - CORE_WAIT: decrement each cycle. When counter==0: `core_rst` <= 0, `rst_done` <= 1, go to RUN.
  - RUN: steady state. On `sw_rst_req`=1: `periph_rst` <= 1, `core_rst` <= 1, `rst_done` <= 0, counter <= `SW_RST_CYCLES`-1, `rst_cause` <= 10, go to SW_HOLD.
  - SW_HOLD: decrement each cycle. When counter==0: go to WAIT_LOCK. If `lock_s` is already 1, sequencing proceeds from there immediately.
- Lock loss: `lock_s`=0 in PERIPH_WAIT, CORE_WAIT, RUN or SW_HOLD. On that edge:
  - `periph_rst` <= 1, `core_rst` <= 1, `rst_done` <= 0, `rst_cause` <= 01, go to WAIT_LOCK.
- Priority: lock loss > software request > counter progress.
- `sw_rst_req` is ignored outside RUN. It is not queued.
- `rst_cause` changes only on the events above and holds otherwise.
- Invariant: `core_rst`=0 implies `periph_rst`=0. Peripherals always leave reset first and enter it together with the core.

## Timing
- Edge numbering: edge 1 is the first rising edge sampling `pll_lock`=1 with `in_rst_n` high.
  - `lock_s` rises after edge `SYNC_STAGES`.
  - FSM leaves WAIT_LOCK at edge `SYNC_STAGES`+1.
  - `periph_rst` falls after edge `SYNC_STAGES`+1+`PERIPH_DELAY`.
  - `core_rst` and `rst_done` change after edge `SYNC_STAGES`+1+`PERIPH_DELAY`+`CORE_DELAY`.
  - Defaults: edges 11 and 27.
- Lock loss: resets assert 1 edge after `lock_s` falls, i.e. `SYNC_STAGES`+1 edges after `pll_lock` falls.
- Software reset (`sw_rst_req` sampled at edge N in RUN):
  - Resets assert after edge N.
  - WAIT_LOCK is entered after edge N+`SW_RST_CYCLES`.
  - With lock held: `periph_rst` falls after N+`SW_RST_CYCLES`+1+`PERIPH_DELAY`; `core_rst` falls `CORE_DELAY` edges later.
- `in_rst_n` assertion mid-sequence: immediate asynchronous return to reset values. Sequencing restarts from edge 1 after deassertion.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Power-up, defaults, `pll_lock` high before `in_rst_n` release -> `periph_rst` falls after edge 11, `core_rst`/`rst_done` after edge 27, `rst_cause`=00.
- `pll_lock` drops during PERIPH_WAIT (edge 6), returns at edge 20 -> resets stay 1; sequence restarts, `periph_rst` falls 11 edges after edge 20; `rst_cause`=01.
- In RUN, `pll_lock` low for 1 cycle -> both resets 1 at edge 3 after the drop, `rst_done`=0, `rst_cause`=01, full re-sequence.
- In RUN, `sw_rst_req` pulse at edge N -> resets 1 from N+1 to N+32; `periph_rst` falls after N+41, `core_rst` after N+57; `rst_cause`=10.
- `sw_rst_req` in the same edge `lock_s` falls -> `rst_cause`=01, state WAIT_LOCK; a second `sw_rst_req` during CORE_WAIT has no effect.
- `in_rst_n` asserted mid SW_HOLD -> outputs asynchronously 1/1/0/00 before the next edge; after release, nominal power-up timing.
